acc_unit: RTL and testbench

- Accumulator/execute stage directly downstream of the registered 32-bit operand-select mux; consumes its zero-extended output word on `din`.
- Holds a WIDTH-bit accumulator and applies one operation per `start` command.
  - Single-cycle ops: load, add, subtract, AND, clear, no-op.
  - Multi-cycle serial shifts: one bit position per clock, with busy/done handshake.
- Drives zero/carry flags for the sequencing controller.

---
 rtl/acc_unit.sv | 187 ++++++++++++++++++
 tb/tb_acc_unit.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/acc_unit.sv
// acc_unit: accumulator / execute stage fed by the registered operand-select mux.
// Applies one operation per accepted start command. Load, add, subtract, AND,
// clear and no-op complete in one cycle. Shifts run serially, one bit position
// per clock, under a busy/done handshake. zero and carry are registered flags
// for the sequencing controller.
//
// Build option: define ACC_UNIT_ROTATE_EN to make op 100/101 rotate-left /
// rotate-right instead of logical shifts. Ports and timing are identical.

module acc_unit #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [2:0]         op,
    input  logic [WIDTH-1:0]   din,
    input  logic [SHAMT_W-1:0] amt,
    output logic [WIDTH-1:0]   acc,
    output logic               busy,
    output logic               done,
    output logic               zero,
    output logic               carry
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    typedef enum logic [2:0] {
        OP_NOP  = 3'b000,
        OP_LOAD = 3'b001,
        OP_ADD  = 3'b010,
        OP_SUB  = 3'b011,
        OP_SHL  = 3'b100,
        OP_SHR  = 3'b101,
        OP_AND  = 3'b110,
        OP_CLR  = 3'b111
    } op_t;

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   acc_nxt;
    logic               carry_nxt;
    logic               busy_nxt;
    logic               done_nxt;
    logic [SHAMT_W-1:0] cnt, cnt_nxt;
    logic               dir, dir_nxt;    // 0: toward MSB, 1: toward LSB
    logic [WIDTH:0]     sum_w;
    logic [WIDTH:0]     diff_w;
    logic [WIDTH:0]     step_w;

    // One serial step toward the MSB; returns {bit shifted out, new value}.
    function automatic logic [WIDTH:0] step_left(input logic [WIDTH-1:0] v);
        logic fill;
`ifdef ACC_UNIT_ROTATE_EN
        fill = v[WIDTH-1];
`else
        fill = 1'b0;
`endif
        return {v[WIDTH-1], v[WIDTH-2:0], fill};
    endfunction

    // One serial step toward the LSB; returns {bit shifted out, new value}.
    function automatic logic [WIDTH:0] step_right(input logic [WIDTH-1:0] v);
        logic fill;
`ifdef ACC_UNIT_ROTATE_EN
        fill = v[0];
`else
        fill = 1'b0;
`endif
        return {v[0], fill, v[WIDTH-1:1]};
    endfunction

    // Arithmetic datapath: WIDTH+1-bit sum and difference; the top bit of the
    // difference is the unsigned borrow (din > acc).
    always_comb begin
        sum_w  = {1'b0, acc} + {1'b0, din};
        diff_w = {1'b0, acc} - {1'b0, din};
        step_w = dir ? step_right(acc) : step_left(acc);
    end

    // Next-state and next-register logic for the IDLE/SHIFT controller.
    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        carry_nxt = carry;
        busy_nxt  = busy;
        done_nxt  = 1'b0;
        cnt_nxt   = cnt;
        dir_nxt   = dir;

        unique case (state)
            IDLE: begin
                if (start) begin
                    case (op_t'(op))
                        OP_NOP: begin
                            done_nxt = 1'b1;
                        end
                        OP_LOAD: begin
                            acc_nxt   = din;
                            carry_nxt = 1'b0;
                            done_nxt  = 1'b1;
                        end
                        OP_ADD: begin
                            acc_nxt   = sum_w[WIDTH-1:0];
                            carry_nxt = sum_w[WIDTH];
                            done_nxt  = 1'b1;
                        end
                        OP_SUB: begin
                            acc_nxt   = diff_w[WIDTH-1:0];
                            carry_nxt = diff_w[WIDTH];
                            done_nxt  = 1'b1;
                        end
                        OP_SHL, OP_SHR: begin
                            // A zero-length shift completes like a NOP.
                            if (amt == '0) begin
                                done_nxt = 1'b1;
                            end else begin
                                cnt_nxt   = amt;
                                dir_nxt   = op[0];
                                busy_nxt  = 1'b1;
                                state_nxt = SHIFT;
                            end
                        end
                        OP_AND: begin
                            acc_nxt   = acc & din;
                            carry_nxt = 1'b0;
                            done_nxt  = 1'b1;
                        end
                        OP_CLR: begin
                            acc_nxt   = '0;
                            carry_nxt = 1'b0;
                            done_nxt  = 1'b1;
                        end
                        default: begin
                            done_nxt = 1'b1;
                        end
                    endcase
                end
            end

            SHIFT: begin
                // start is deliberately not examined here: commands issued
                // while busy are dropped, not queued.
                acc_nxt   = step_w[WIDTH-1:0];
                carry_nxt = step_w[WIDTH];
                cnt_nxt   = cnt - 1'b1;
                if (cnt == SHAMT_W'(1)) begin
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    // State register; synchronous reset overrides everything, including a shift in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            acc   <= '0;
            zero  <= 1'b1;
            carry <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            cnt   <= '0;
            dir   <= 1'b0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            zero  <= (acc_nxt == '0);
            carry <= carry_nxt;
            busy  <= busy_nxt;
            done  <= done_nxt;
            cnt   <= cnt_nxt;
            dir   <= dir_nxt;
        end
    end

endmodule

// File: tb/tb_acc_unit.sv
// tb_acc_unit: directed plus randomized checks of acc_unit against an
// arithmetic reference model. Honours ACC_UNIT_ROTATE_EN the same way as the RTL.

module tb_acc_unit;

    localparam int WIDTH   = 32;
    localparam int SHAMT_W = 5;

    logic               clock = 1'b0;
    logic               reset;
    logic               start;
    logic [2:0]         op;
    logic [WIDTH-1:0]   din;
    logic [SHAMT_W-1:0] amt;
    logic [WIDTH-1:0]   acc;
    logic               busy;
    logic               done;
    logic               zero;
    logic               carry;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit [31:0] m_acc;
    bit        m_carry;

    acc_unit #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) dut (
        .clock (clock),
        .reset (reset),
        .start (start),
        .op    (op),
        .din   (din),
        .amt   (amt),
        .acc   (acc),
        .busy  (busy),
        .done  (done),
        .zero  (zero),
        .carry (carry)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Whole-operation result from the arithmetic definition of each op code.
    task automatic model_apply(input logic [2:0] o, input logic [31:0] d, input logic [4:0] a);
        logic [32:0] s;
        logic [63:0] x;
        case (o)
            3'd0: ;
            3'd1: begin m_acc = d; m_carry = 1'b0; end
            3'd2: begin s = {1'b0, m_acc} + {1'b0, d}; m_acc = s[31:0]; m_carry = s[32]; end
            3'd3: begin m_carry = (d > m_acc); m_acc = m_acc - d; end
            3'd4: if (a != 0) begin
`ifdef ACC_UNIT_ROTATE_EN
                m_acc = (m_acc << a) | (m_acc >> (32 - a));
                m_carry = m_acc[0];
`else
                x = {32'b0, m_acc} << a;
                m_acc = x[31:0];
                m_carry = x[32];
`endif
            end
            3'd5: if (a != 0) begin
`ifdef ACC_UNIT_ROTATE_EN
                m_acc = (m_acc >> a) | (m_acc << (32 - a));
                m_carry = m_acc[31];
`else
                x = {m_acc, 32'b0} >> a;
                m_acc = x[63:32];
                m_carry = x[31];
`endif
            end
            3'd6: begin m_acc = m_acc & d; m_carry = 1'b0; end
            default: begin m_acc = '0; m_carry = 1'b0; end
        endcase
    endtask

    task automatic check_state(input string tag, input bit eb, input bit ed);
        chk({tag, ".acc"},   acc,   m_acc);
        chk({tag, ".carry"}, carry, m_carry);
        chk({tag, ".zero"},  zero,  (m_acc == 0));
        chk({tag, ".busy"},  busy,  eb);
        chk({tag, ".done"},  done,  ed);
    endtask

    // Issue one command and follow it to completion.
    // noise: 0 quiet, 1 random start/op/din/amt while busy, 2 start+CLR held while busy.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] d,
                          input logic [4:0] a, input int noise);
        int  n;
        bit  got;
        @(negedge clock);
        start = 1'b1; op = o; din = d; amt = a;
        model_apply(o, d, a);
        @(negedge clock);
        start = 1'b0; din = $urandom; amt = $urandom; op = 3'($urandom);
        if (o[2:1] == 2'b10 && a != 0) begin
            chk({tag, ".busy1"}, busy, 1'b1);
            chk({tag, ".done1"}, done, 1'b0);
            n = 1;
            got = 1'b0;
            for (int i = 0; i < 80 && !got; i++) begin
                if (noise == 1) begin
                    start = 1'($urandom); op = 3'($urandom); din = $urandom; amt = $urandom;
                end else if (noise == 2) begin
                    start = 1'b1; op = 3'b111; din = $urandom;
                end
                @(negedge clock);
                n++;
                if (done) begin
                    got = 1'b1;
                    start = 1'b0;
                end else if (busy !== 1'b1) begin
                    chk({tag, ".busy_hold"}, busy, 1'b1);
                end
            end
            chk({tag, ".latency"}, n, a + 1);
        end
        check_state(tag, 1'b0, 1'b1);
    endtask

    logic [2:0] r_op;
    logic [31:0] exp_c;

    initial begin
        reset = 1'b1; start = 1'b0; op = '0; din = '0; amt = '0;
        m_acc = '0; m_carry = 1'b0;
        repeat (2) @(negedge clock);
        check_state("reset", 1'b0, 1'b0);
        reset = 1'b0;

        // LOAD, then done must fall after one cycle
        run_op("load_ab", 3'b001, 32'h0000_00AB, 5'd0, 0);
        @(negedge clock);
        chk("done_pulse", done, 1'b0);

        // ADD wrap
        run_op("load_ff", 3'b001, 32'hFFFF_FFFF, 5'd0, 0);
        run_op("add_wrap", 3'b010, 32'h0000_0001, 5'd0, 0);
        chk("add_wrap.const", {carry, acc}, 33'h1_0000_0000);

        // SUB with and without borrow
        run_op("load_5", 3'b001, 32'h5, 5'd0, 0);
        run_op("sub_borrow", 3'b011, 32'h7, 5'd0, 0);
        chk("sub_borrow.const", {carry, acc}, 33'h1_FFFF_FFFE);
        run_op("sub_zero", 3'b011, 32'hFFFF_FFFE, 5'd0, 0);
        chk("sub_zero.const", {zero, carry, acc}, 34'h2_0000_0000);

        // SHL 3 of 0x8000_0001
        run_op("load_81", 3'b001, 32'h8000_0001, 5'd0, 0);
        run_op("shl3", 3'b100, 32'h0, 5'd3, 0);
`ifdef ACC_UNIT_ROTATE_EN
        exp_c = 32'h0000_000C;
`else
        exp_c = 32'h0000_0008;
`endif
        chk("shl3.const", {carry, acc}, {1'b0, exp_c});

        // SHR amt=0 is single-cycle, acc and carry unchanged
        run_op("load_x", 3'b001, 32'hDEAD_BEEF, 5'd0, 0);
        run_op("shr0", 3'b101, 32'h0, 5'd0, 0);

        // CLR held during a shift must be ignored
        run_op("load_81b", 3'b001, 32'h8000_0001, 5'd0, 0);
        run_op("shr5_clr", 3'b101, 32'h0, 5'd5, 2);

        // Back-to-back single-cycle ops at one per clock
        @(negedge clock);
        start = 1'b1; op = 3'b001; din = $urandom;
        model_apply(op, din, 5'd0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            check_state("b2b", 1'b0, 1'b1);
            if (k < 9) begin
                do r_op = 3'($urandom); while (r_op[2:1] == 2'b10);
                op = r_op; din = $urandom;
                model_apply(op, din, 5'd0);
            end else begin
                start = 1'b0;
            end
        end

        // Reset in the middle of a 20-step shift
        run_op("load_m", 3'b001, 32'hA5A5_0F0F, 5'd0, 0);
        @(negedge clock);
        start = 1'b1; op = 3'b100; din = '0; amt = 5'd20;
        @(negedge clock);
        start = 1'b0;
        repeat (3) @(negedge clock);
        chk("midshift.busy", busy, 1'b1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        m_acc = '0; m_carry = 1'b0;
        check_state("midreset", 1'b0, 1'b0);
        run_op("load_1234", 3'b001, 32'h0000_1234, 5'd0, 0);

        // Randomized commands, half with bus noise while busy
        for (int k = 0; k < 150; k++) begin
            run_op("rand", 3'($urandom), $urandom, 5'($urandom), int'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
